// File: rtl/jacobi_sched_pkg.sv
// jacobi_sched_pkg
//   Shared definitions for the Jacobi job scheduler:
//   - state_t : scheduler FSM state encoding
//   - DMA/KERN: scratchpad owner values driven on spm_sel
//   - kern_owns(): which states hand the scratchpad to the kernel
package jacobi_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    KSTART = 3'd2,
    KRUN   = 3'd3,
    STORE  = 3'd4,
    FINISH = 3'd5,
    FAULT  = 3'd6
  } state_t;

  localparam logic DMA  = 1'b0;
  localparam logic KERN = 1'b1;

  function automatic logic kern_owns(input state_t s);
    return (s == KSTART) || (s == KRUN);
  endfunction

endpackage

// File: rtl/jacobi_sched_watchdog.sv
// sched_watchdog
//   Kernel watchdog counter. Counts cycles while enable is high and flags
//   expired in the cycle whose count reaches limit. A limit of 0 never expires.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   clear           : zero the counter (takes priority over enable)
//   enable          : count this cycle
//   limit [TMO_W]   : expiry threshold in counted cycles
//   expired         : combinational, high when this cycle's count hits limit
module sched_watchdog #(
  parameter int TMO_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] count_reg;
  logic [TMO_W:0]   count_inc;

  // One extra bit so the compare stays correct near the top of the range.
  assign count_inc = {1'b0, count_reg} + {{TMO_W{1'b0}}, 1'b1};
  assign expired   = enable && (limit != '0) && (count_inc >= {1'b0, limit});

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_inc[TMO_W-1:0];
    end
  end

endmodule

// File: rtl/jacobi_sched.sv
// jacobi_sched
//   Sequences one Jacobi job: DMA load, num_iters kernel invocations, DMA
//   store, then a done pulse. A watchdog guards every kernel invocation.
// Build option:
//   JACOBI_SCHED_PERF_EN : when defined, perf_cycles counts kernel-owned
//                          cycles (wraps at 2^64); otherwise it is tied to 0.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   start, abort                       : job request / cancel
//   num_words, num_iters, tmo_limit    : job parameters, sampled on accepted start
//   load_done, store_done, kern_done   : completion pulses from the engines
//   load_start, store_start, kern_start: one-cycle start pulses (kern_start = ap_start)
//   spm_sel                            : scratchpad owner (DMA / KERN)
//   busy, done, fault                  : job active, completion pulse, sticky watchdog fault
//   iter_cnt                           : finished kernel invocations in this job
//   perf_cycles                        : kernel-owned cycle counter
module jacobi_sched
  import jacobi_sched_pkg::*;
#(
  parameter int TMO_W       = 32,
  parameter int MAX_ITERS_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [63:0]            num_words,
  input  logic [MAX_ITERS_W-1:0] num_iters,
  input  logic [TMO_W-1:0]       tmo_limit,
  input  logic                   load_done,
  input  logic                   store_done,
  input  logic                   kern_done,
  output logic                   load_start,
  output logic                   store_start,
  output logic                   kern_start,
  output logic                   spm_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic [MAX_ITERS_W-1:0] iter_cnt,
  output logic [63:0]            perf_cycles
);

  state_t                 state_reg, state_next;
  logic [MAX_ITERS_W-1:0] num_iters_reg;
  logic [TMO_W-1:0]       tmo_limit_reg;
  logic [MAX_ITERS_W-1:0] iter_cnt_reg;
  logic                   load_start_reg, store_start_reg, kern_start_reg, done_reg;
  logic                   load_start_next, store_start_next, kern_start_next, done_next;
  logic                   busy_reg, fault_reg, spm_sel_reg;
  logic                   accept, iter_inc, wd_expired;
  logic [MAX_ITERS_W:0]   iter_plus1;

  assign iter_plus1 = {1'b0, iter_cnt_reg} + {{MAX_ITERS_W{1'b0}}, 1'b1};

  // Watchdog restarts on every kernel launch; a kern_done cycle never counts,
  // so a completion landing on the limit cycle wins over the expiry.
  sched_watchdog #(.TMO_W(TMO_W)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_reg == KSTART),
    .enable  ((state_reg == KRUN) && !kern_done),
    .limit   (tmo_limit_reg),
    .expired (wd_expired)
  );

  always_comb begin
    state_next       = state_reg;
    load_start_next  = 1'b0;
    store_start_next = 1'b0;
    kern_start_next  = 1'b0;
    done_next        = 1'b0;
    accept           = 1'b0;
    iter_inc         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (num_words == 64'd0) begin
            state_next = FINISH;
          end else begin
            state_next      = LOAD;
            load_start_next = 1'b1;
          end
        end
      end
      LOAD: begin
        if (load_done) begin
          if (num_iters_reg == '0) begin
            state_next       = STORE;
            store_start_next = 1'b1;
          end else begin
            state_next      = KSTART;
            kern_start_next = 1'b1;
          end
        end
      end
      KSTART: state_next = KRUN;
      KRUN: begin
        if (kern_done) begin
          iter_inc = 1'b1;
          if (iter_plus1 < {1'b0, num_iters_reg}) begin
            state_next      = KSTART;
            kern_start_next = 1'b1;
          end else begin
            state_next       = STORE;
            store_start_next = 1'b1;
          end
        end else if (wd_expired) begin
          state_next = FAULT;
        end
      end
      STORE: begin
        if (store_done) state_next = FINISH;
      end
      FINISH: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
    // Abort overrides everything that would have happened this cycle.
    if (abort && (state_reg != IDLE)) begin
      state_next       = IDLE;
      load_start_next  = 1'b0;
      store_start_next = 1'b0;
      kern_start_next  = 1'b0;
      done_next        = 1'b0;
      iter_inc         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      num_iters_reg   <= '0;
      tmo_limit_reg   <= '0;
      iter_cnt_reg    <= '0;
      load_start_reg  <= 1'b0;
      store_start_reg <= 1'b0;
      kern_start_reg  <= 1'b0;
      done_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      fault_reg       <= 1'b0;
      spm_sel_reg     <= DMA;
    end else begin
      state_reg       <= state_next;
      load_start_reg  <= load_start_next;
      store_start_reg <= store_start_next;
      kern_start_reg  <= kern_start_next;
      done_reg        <= done_next;
      busy_reg        <= (state_next != IDLE);
      spm_sel_reg     <= kern_owns(state_next) ? KERN : DMA;
      if (accept) begin
        num_iters_reg <= num_iters;
        tmo_limit_reg <= tmo_limit;
        iter_cnt_reg  <= '0;
        fault_reg     <= 1'b0;
      end else if (iter_inc) begin
        iter_cnt_reg <= iter_plus1[MAX_ITERS_W-1:0];
      end
      // Fault stays set through abort; only a new accepted start clears it.
      if ((state_reg == KRUN) && (state_next == FAULT)) fault_reg <= 1'b1;
    end
  end

`ifdef JACOBI_SCHED_PERF_EN
  logic [63:0] perf_reg;
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reg <= '0;
    end else if (spm_sel_reg == KERN) begin
      perf_reg <= perf_reg + 64'd1;
    end
  end
  assign perf_cycles = perf_reg;
`else
  assign perf_cycles = 64'd0;
`endif

  assign load_start  = load_start_reg;
  assign store_start = store_start_reg;
  assign kern_start  = kern_start_reg;
  assign done        = done_reg;
  assign busy        = busy_reg;
  assign fault       = fault_reg;
  assign spm_sel     = spm_sel_reg;
  assign iter_cnt    = iter_cnt_reg;

endmodule
